// File: rtl/sim_mem_sequencer.sv
// Load -> run -> dump -> clear sequencer wrapped around the riscV datapath and its memories.
// Loads take one cycle from handshake to imem write; dump words appear RD_LAT cycles after their read issue.
module sim_mem_sequencer #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter int                ADDR_STEP  = 4,
    parameter logic [ADDR_W-1:0] IMEM_BASE  = '0,
    parameter int                IMEM_WORDS = 1024,
    parameter logic [ADDR_W-1:0] DMEM_BASE  = ADDR_W'(32'h1001_0000),
    parameter int                DUMP_WORDS = 256,
    parameter int                RUN_CYCLES = 4096,
    parameter int                RD_LAT     = 1,
    parameter bit                CLEAR_EN   = 1'b1
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              imem_wr_n,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_data,
    input  logic [ADDR_W-1:0] dut_pc,
    input  logic              dut_halt,
    output logic              dut_rst,
    output logic              dmem_own,
    output logic              dmem_rd,
    output logic              dmem_wr_n,
    output logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              end_sim,
    output logic              timeout,
    output logic              overflow
);

    localparam int LC_W = $clog2(IMEM_WORDS + 1);
    localparam int RC_W = $clog2(RUN_CYCLES) + 1;
    localparam int DI_W = $clog2(DUMP_WORDS) + 1;
    localparam int DR_W = $clog2(RD_LAT) + 1;

    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(ADDR_STEP);
    localparam logic [LC_W-1:0]   IMEM_CAP   = LC_W'(IMEM_WORDS);
    localparam logic [RC_W-1:0]   RUN_LAST   = RC_W'(RUN_CYCLES - 1);
    localparam logic [DI_W-1:0]   DUMP_LAST  = DI_W'(DUMP_WORDS - 1);
    localparam logic [DR_W-1:0]   DRAIN_LAST = DR_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DUMP,
        S_DRAIN,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t              state_q;
    logic                ld_ready_q;
    logic                ld_last_q;
    logic                imem_wr_n_q;
    logic [ADDR_W-1:0]   imem_addr_q;
    logic [DATA_W-1:0]   imem_data_q;
    logic [ADDR_W-1:0]   ld_addr_q;
    logic [LC_W-1:0]     ld_cnt_q;
    logic [RC_W-1:0]     run_cnt_q;
    logic [DI_W-1:0]     idx_q;
    logic [DR_W-1:0]     drain_cnt_q;
    logic                dut_rst_q;
    logic                dmem_own_q;
    logic                dmem_rd_q;
    logic                dmem_wr_n_q;
    logic [ADDR_W-1:0]   dmem_addr_q;
    logic                end_sim_q;
    logic                timeout_q;
    logic                overflow_q;
    logic [RD_LAT-1:0]   pipe_vld_q;
    logic [ADDR_W-1:0]   pipe_addr_q [RD_LAT];

    logic                ld_hs;
    logic                ld_keep;
    logic                run_exp;
    logic [ADDR_W-1:0]   ld_addr_d;
    logic [ADDR_W-1:0]   dmem_addr_d;

    assign ld_hs       = ld_valid & ld_ready_q;
    assign ld_keep     = (ld_cnt_q < IMEM_CAP);
    assign run_exp     = (run_cnt_q == RUN_LAST);
    assign ld_addr_d   = ld_addr_q + STEP;
    assign dmem_addr_d = dmem_addr_q + STEP;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= S_IDLE;
            ld_ready_q  <= 1'b0;
            ld_last_q   <= 1'b0;
            imem_wr_n_q <= 1'b1;
            imem_addr_q <= IMEM_BASE;
            imem_data_q <= '0;
            ld_addr_q   <= IMEM_BASE;
            ld_cnt_q    <= '0;
            run_cnt_q   <= '0;
            idx_q       <= '0;
            drain_cnt_q <= '0;
            dut_rst_q   <= 1'b1;
            dmem_own_q  <= 1'b0;
            dmem_rd_q   <= 1'b0;
            dmem_wr_n_q <= 1'b1;
            dmem_addr_q <= DMEM_BASE;
            end_sim_q   <= 1'b0;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            // A write strobe lasts exactly one cycle unless re-armed below.
            imem_wr_n_q <= 1'b1;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q     <= S_LOAD;
                        ld_ready_q  <= 1'b1;
                        ld_last_q   <= 1'b0;
                        end_sim_q   <= 1'b0;
                        timeout_q   <= 1'b0;
                        overflow_q  <= 1'b0;
                        ld_cnt_q    <= '0;
                        run_cnt_q   <= '0;
                        idx_q       <= '0;
                        drain_cnt_q <= '0;
                        ld_addr_q   <= IMEM_BASE;
                        imem_addr_q <= IMEM_BASE;
                    end
                end
                S_LOAD: begin
                    if (ld_hs) begin
                        if (ld_keep) begin
                            imem_wr_n_q <= 1'b0;
                            imem_addr_q <= ld_addr_q;
                            imem_data_q <= ld_data;
                            ld_addr_q   <= ld_addr_d;
                            ld_cnt_q    <= ld_cnt_q + LC_W'(1);
                        end else begin
                            overflow_q  <= 1'b1;
                        end
                        if (ld_last) begin
                            ld_ready_q <= 1'b0;
                            ld_last_q  <= 1'b1;
                        end
                    end
                    // The final write is on the bus this cycle; release the DUT next.
                    if (ld_last_q) begin
                        state_q   <= S_RUN;
                        ld_last_q <= 1'b0;
                        dut_rst_q <= 1'b0;
                        run_cnt_q <= '0;
                    end
                end
                S_RUN: begin
                    run_cnt_q <= run_cnt_q + RC_W'(1);
                    if (dut_halt || run_exp) begin
                        state_q     <= S_DUMP;
                        timeout_q   <= ~dut_halt;
                        dut_rst_q   <= 1'b1;
                        dmem_own_q  <= 1'b1;
                        dmem_rd_q   <= 1'b1;
                        dmem_addr_q <= DMEM_BASE;
                        idx_q       <= '0;
                    end
                end
                S_DUMP: begin
                    if (idx_q == DUMP_LAST) begin
                        state_q     <= S_DRAIN;
                        dmem_rd_q   <= 1'b0;
                        drain_cnt_q <= '0;
                    end else begin
                        idx_q       <= idx_q + DI_W'(1);
                        dmem_addr_q <= dmem_addr_d;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        if (CLEAR_EN) begin
                            state_q     <= S_CLEAR;
                            dmem_wr_n_q <= 1'b0;
                            dmem_addr_q <= DMEM_BASE;
                            idx_q       <= '0;
                        end else begin
                            state_q     <= S_DONE;
                            dmem_own_q  <= 1'b0;
                            end_sim_q   <= 1'b1;
                        end
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DR_W'(1);
                    end
                end
                S_CLEAR: begin
                    if (idx_q == DUMP_LAST) begin
                        state_q     <= S_DONE;
                        dmem_wr_n_q <= 1'b1;
                        dmem_own_q  <= 1'b0;
                        end_sim_q   <= 1'b1;
                    end else begin
                        idx_q       <= idx_q + DI_W'(1);
                        dmem_addr_q <= dmem_addr_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Issued read addresses ride alongside the memory's own read latency.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            pipe_vld_q <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_addr_q[k] <= '0;
            end
        end else begin
            pipe_vld_q[0]  <= dmem_rd_q;
            pipe_addr_q[0] <= dmem_addr_q;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_vld_q[k]  <= pipe_vld_q[k-1];
                pipe_addr_q[k] <= pipe_addr_q[k-1];
            end
        end
    end

    assign ld_ready   = ld_ready_q;
    assign imem_wr_n  = imem_wr_n_q;
    assign imem_addr  = (state_q == S_RUN) ? dut_pc : imem_addr_q;
    assign imem_data  = imem_data_q;
    assign dut_rst    = dut_rst_q;
    assign dmem_own   = dmem_own_q;
    assign dmem_rd    = dmem_rd_q;
    assign dmem_wr_n  = dmem_wr_n_q;
    assign dmem_addr  = dmem_addr_q;
    assign dump_valid = pipe_vld_q[RD_LAT-1];
    assign dump_addr  = pipe_vld_q[RD_LAT-1] ? pipe_addr_q[RD_LAT-1] : '0;
    assign dump_data  = pipe_vld_q[RD_LAT-1] ? dmem_rdata : '0;
    assign end_sim    = end_sim_q;
    assign timeout    = timeout_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_sim_mem_sequencer.sv
// Scoreboard bench for sim_mem_sequencer: small imem capacity, short run timeout, 4-word dump with RD_LAT=2.
module tb_sim_mem_sequencer;

    localparam int          IMEM_WORDS = 4;
    localparam int          RUN_CYCLES = 10;
    localparam int          DUMP_WORDS = 4;
    localparam int          RD_LAT     = 2;
    localparam logic [31:0] DBASE      = 32'h1001_0000;

    logic        CLK;
    logic        RST_n;
    logic        start;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        imem_wr_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] dut_pc;
    logic        dut_halt;
    logic        dut_rst;
    logic        dmem_own;
    logic        dmem_rd;
    logic        dmem_wr_n;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_rdata;
    logic        dump_valid;
    logic [31:0] dump_addr;
    logic [31:0] dump_data;
    logic        end_sim;
    logic        timeout;
    logic        overflow;

    sim_mem_sequencer #(
        .IMEM_WORDS (IMEM_WORDS),
        .DUMP_WORDS (DUMP_WORDS),
        .RUN_CYCLES (RUN_CYCLES),
        .RD_LAT     (RD_LAT),
        .CLEAR_EN   (1'b1)
    ) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .start      (start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .imem_wr_n  (imem_wr_n),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dut_pc     (dut_pc),
        .dut_halt   (dut_halt),
        .dut_rst    (dut_rst),
        .dmem_own   (dmem_own),
        .dmem_rd    (dmem_rd),
        .dmem_wr_n  (dmem_wr_n),
        .dmem_addr  (dmem_addr),
        .dmem_rdata (dmem_rdata),
        .dump_valid (dump_valid),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .end_sim    (end_sim),
        .timeout    (timeout),
        .overflow   (overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        imem_q[$];
    ent_t        dump_q[$];
    logic [31:0] prog[$];

    // Data memory model: RD_LAT=2 read pipe, zero-write while sequencer owns the bus.
    logic [31:0] dmem [16];
    logic [31:0] rd_p1;
    logic [31:0] rd_p2;
    logic [31:0] moff;
    always @(posedge CLK) begin
        moff = dmem_addr - DBASE;
        if (dmem_own && dmem_rd && moff < 32'd64) rd_p1 <= dmem[moff[5:2]];
        else                                      rd_p1 <= 32'hDEAD_BEEF;
        rd_p2 <= rd_p1;
        if (dmem_own && !dmem_wr_n && moff < 32'd64) dmem[moff[5:2]] = 32'h0;
    end
    assign dmem_rdata = rd_p2;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int first_rd, first_dv, last_dv, dv_cnt;

    always @(negedge CLK) begin
        if (RST_n) begin
            if (!imem_wr_n) begin
                check("imem_wr_expected", imem_q.size() != 0, 1'b1);
                if (imem_q.size() != 0) check("imem_wr", {imem_addr, imem_data}, imem_q.pop_front());
            end
            if (dmem_rd && first_rd < 0) first_rd = cyc;
            if (dump_valid) begin
                if (first_dv < 0) first_dv = cyc;
                last_dv = cyc;
                dv_cnt++;
                check("dump_expected", dump_q.size() != 0, 1'b1);
                if (dump_q.size() != 0) check("dump_word", {dump_addr, dump_data}, dump_q.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_mon;
        first_rd = -1;
        first_dv = -1;
        last_dv  = -1;
        dv_cnt   = 0;
    endtask

    task automatic preload(input logic [31:0] v0);
        ent_t e;
        for (int i = 0; i < DUMP_WORDS; i++) begin
            dmem[i] = v0 + 32'(i);
            e.a = DBASE + 32'(i * 4);
            e.d = v0 + 32'(i);
            dump_q.push_back(e);
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ctl"}, {ld_ready, imem_wr_n, dut_rst, dmem_own, dmem_rd, dmem_wr_n,
                              dump_valid, end_sim, timeout, overflow}, 10'b0110010000);
        check({tag, "_imem"}, {imem_addr, imem_data}, 64'h0);
        check({tag, "_dmem_addr"}, dmem_addr, DBASE);
        check({tag, "_dump"}, {dump_addr, dump_data}, 64'h0);
    endtask

    task automatic load_prog(input bit gap);
        ent_t e;
        int   w;
        bit   ovf;
        ovf = prog.size() > IMEM_WORDS;
        for (int k = 0; k < prog.size(); k++) begin
            if (gap && k == 2) begin
                ld_valid = 1'b0;
                tick();
            end
            ld_valid = 1'b1;
            ld_data  = prog[k];
            ld_last  = (k == prog.size() - 1);
            w = 0;
            while (!ld_ready && w < 20) begin
                tick();
                w++;
            end
            if (!ld_ready) check("ld_ready_timeout", ld_ready, 1'b1);
            if (k < IMEM_WORDS) begin
                e.a = 32'(k * 4);
                e.d = prog[k];
                imem_q.push_back(e);
            end
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("ld_ready_drop", ld_ready, 1'b0);
        check("last_wr_n", imem_wr_n, ovf);
        check("rst_held_load", dut_rst, 1'b1);
        tick();
        check("run_entry_rst", dut_rst, 1'b0);
        check("run_wr_n", imem_wr_n, 1'b1);
        check("overflow", overflow, ovf);
        dut_pc = 32'h0000_0040;
        #1;
        check("pc_mux", imem_addr, 32'h0000_0040);
    endtask

    task automatic run_phase(input int halt_at, input bit poke_start, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (dut_rst) break;
            dut_halt = (n == halt_at);
            start    = poke_start && (n == 1);
            n++;
            tick();
        end
        dut_halt = 1'b0;
        start    = 1'b0;
    endtask

    task automatic finish_seq(input string tag);
        int w;
        w = 0;
        while (!end_sim && w < 60) begin
            tick();
            w++;
        end
        check({tag, "_end_sim"}, end_sim, 1'b1);
        check({tag, "_dv_count"}, dv_cnt, DUMP_WORDS);
        check({tag, "_dv_latency"}, first_dv - first_rd, RD_LAT);
        check({tag, "_dv_contig"}, last_dv - first_dv, DUMP_WORDS - 1);
        for (int i = 0; i < DUMP_WORDS; i++) check({tag, "_cleared"}, dmem[i], 32'h0);
        check({tag, "_done_ctl"}, {dmem_own, dut_rst, dmem_wr_n}, 3'b011);
        check({tag, "_dump_q_empty"}, dump_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        start    = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;
        dut_pc   = '0;
        dut_halt = 1'b0;
        RST_n    = 1'b1;
        reset_mon();
        #2 RST_n = 1'b0;
        #1;
        check_reset_state("reset");
        tick();
        tick();
        RST_n = 1'b1;
        tick();

        // Seq A: 4-word program with an ld_valid gap, halt after 4 run cycles.
        prog = '{32'h0000_0013, 32'h0000_0013, 32'h0000_0013, 32'h0010_0073};
        reset_mon();
        preload(32'h0000_00A0);
        pulse_start();
        check("A_ld_ready", ld_ready, 1'b1);
        load_prog(1'b1);
        run_phase(3, 1'b0, n);
        check("A_run_cycles", n, 4);
        check("A_timeout", timeout, 1'b0);
        check("A_dump_own", {dmem_own, dmem_rd}, 2'b11);
        finish_seq("A");
        ld_valid = 1'b1;
        ld_data  = 32'hBAD0_BAD0;
        tick();
        tick();
        ld_valid = 1'b0;
        check("A_done_hold", {end_sim, ld_ready}, 2'b10);

        // Seq B: 5 words into a 4-word imem, no halt, stray start during RUN.
        prog = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        reset_mon();
        preload(32'h0000_00B0);
        pulse_start();
        check("B_restart_clears", end_sim, 1'b0);
        load_prog(1'b0);
        run_phase(-1, 1'b1, n);
        check("B_run_cycles", n, RUN_CYCLES);
        check("B_timeout", timeout, 1'b1);
        finish_seq("B");
        check("B_overflow_sticky", overflow, 1'b1);

        // Seq C: halt on the expiry cycle, then reset in the middle of the dump.
        prog = '{32'h0010_0073};
        reset_mon();
        preload(32'h0000_00D0);
        pulse_start();
        check("C_clears_flags", {timeout, overflow}, 2'b00);
        load_prog(1'b0);
        run_phase(RUN_CYCLES - 1, 1'b0, n);
        check("C_run_cycles", n, RUN_CYCLES);
        check("C_halt_wins", timeout, 1'b0);
        check("C_dump_own", dmem_own, 1'b1);
        tick();
        tick();
        RST_n = 1'b0;
        #1;
        check_reset_state("midreset");
        dump_q.delete();
        tick();
        RST_n = 1'b1;
        tick();

        // Seq D: full rerun after the abort, halt on the first run cycle.
        prog = '{32'h0000_0013, 32'h0000_0013, 32'h0000_0013, 32'h0010_0073};
        reset_mon();
        preload(32'h0000_00C0);
        pulse_start();
        load_prog(1'b0);
        run_phase(0, 1'b0, n);
        check("D_run_cycles", n, 1);
        check("D_timeout", timeout, 1'b0);
        finish_seq("D");

        check("imem_q_empty", imem_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sim_mem_sequencer.md
Name: sim_mem_sequencer

Overview:
- Synthesizable successor to the bench-level load/run/dump flow for the riscV datapath.
- Streams a program into instruction memory, releases the DUT from reset, and runs it until halt or timeout.
- Then takes ownership of data memory and dumps a parametrised window to an output sink, optionally clearing that window afterwards.
- Sits between Stimuli_generator, Instruction/Data Memory, datapath and Output_Sink.

Parameters:
- DATA_W, 32, memory word width.
- ADDR_W, 32, memory address width.
- ADDR_STEP, 4, address increment per word.
- IMEM_BASE, 0, first instruction address.
- IMEM_WORDS, 1024, instruction memory capacity in words.
- DMEM_BASE, 32'h10010000, first dumped data address.
- DUMP_WORDS, 256, number of words dumped.
- RUN_CYCLES, 4096, run-phase timeout in cycles (must be >= 1).
- RD_LAT, 1, data memory read latency in cycles (must be >= 1).
- CLEAR_EN, 1, if 1, zero the dump window after the dump.

Ports:
- CLK  in  1  clock.
- RST_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that starts a sequence; sampled only in IDLE or DONE.
- ld_valid  in  1  load word valid.
- ld_data  in  DATA_W  load word.
- ld_last  in  1  marks the final load word.
- ld_ready  out  1  sequencer accepts a load word.
- imem_wr_n  out  1  instruction memory write strobe, active low.
- imem_addr  out  ADDR_W  instruction memory address.
- imem_data  out  DATA_W  instruction memory write data.
- dut_pc  in  ADDR_W  DUT PC.
- dut_halt  in  1  DUT end-of-program indication.
- dut_rst  out  1  DUT reset, active high.
- dmem_own  out  1  1 = sequencer drives data memory; 0 = DUT drives it.
- dmem_rd  out  1  data memory read enable.
- dmem_wr_n  out  1  data memory write strobe, active low.
- dmem_addr  out  ADDR_W  data memory address.
- dmem_rdata  in  DATA_W  data memory read data.
- dump_valid  out  1  dump_data/dump_addr are valid.
- dump_addr  out  ADDR_W  address of the dumped word.
- dump_data  out  DATA_W  dumped word.
- end_sim  out  1  sequence complete.
- timeout  out  1  run phase ended by RUN_CYCLES, not by halt.
- overflow  out  1  more than IMEM_WORDS load words were received.

Behaviour:
- Reset (async, RST_n=0):
  - FSM goes to IDLE.
  - ld_ready=0, imem_wr_n=1, imem_addr=IMEM_BASE, imem_data=0, dut_rst=1.
  - dmem_own=0, dmem_rd=0, dmem_wr_n=1, dmem_addr=DMEM_BASE.
  - dump_valid=0, dump_addr=0, dump_data=0.
  - end_sim=0, timeout=0, overflow=0; all counters 0.
  - Reset mid-sequence aborts immediately; no partial write is completed.
- States: IDLE, LOAD, RUN, DUMP, DRAIN, CLEAR, DONE.
- IDLE:
  - dut_rst=1.
  - start -> LOAD; clears timeout, overflow and end_sim, and zeroes all counters.
- LOAD:
  - ld_ready=1.
  - Handshake = ld_valid&ld_ready.
  - Word n (n counts from 0) is written the next cycle: imem_wr_n=0, imem_addr=IMEM_BASE+n*ADDR_STEP, imem_data=word.
  - If n>=IMEM_WORDS, the word is dropped (imem_wr_n stays 1) and overflow is set (sticky).
  - A handshake with ld_last=1: ld_ready drops next cycle, the final write completes, then the FSM enters RUN.
  - ld_valid low: no write, FSM stays in LOAD.
- RUN:
  - dut_rst=0; imem_addr = dut_pc combinationally; imem_wr_n=1; dmem_own=0.
  - Cycle counter increments from 0.
  - dut_halt=1 -> DUMP.
  - Counter reaching RUN_CYCLES-1 without halt -> DUMP with timeout=1.
  - Halt and expiry in the same cycle: halt wins, timeout stays 0.
- DUMP:
  - dut_rst=1, dmem_own=1.
  - One read issued per cycle: dmem_rd=1, dmem_addr=DMEM_BASE+i*ADDR_STEP, i=0..DUMP_WORDS-1.
  - An RD_LAT-deep pipeline carries the address.
  - RD_LAT cycles after issue: dump_valid=1, dump_data=dmem_rdata, dump_addr=issued address.
  - After the last issue -> DRAIN.
- DRAIN:
  - dmem_rd=0; wait RD_LAT cycles so every issued read produces its dump_valid.
  - Then -> CLEAR if CLEAR_EN=1, else -> DONE.
- CLEAR:
  - dmem_wr_n=0 with write data 0 (external mux selects zero while dmem_own=1 and dmem_rd=0), addresses walked as in DUMP, one per cycle, DUMP_WORDS cycles.
  - Then -> DONE.
- DONE:
  - end_sim=1 (held); dut_rst=1; dmem_own=0.
  - start -> LOAD, clearing end_sim, timeout and overflow.
- Total dump_valid pulses per sequence = DUMP_WORDS exactly, contiguous, in ascending address order.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is permitted and not flagged.
- start is ignored outside IDLE/DONE. ld_valid is ignored outside LOAD.

Test Plan:
- Load 4 words (0x00000013×3, 0x00100073 with ld_last) -> writes at addresses 0,4,8,12, then RUN with dut_rst=0 on the cycle after the last write; overflow=0.
- IMEM_WORDS=2, load 3 words -> only addresses 0,4 written, overflow=1, FSM still reaches RUN.
- RUN_CYCLES=10, dut_halt never asserted -> dut_rst returns to 1 after exactly 10 RUN cycles, timeout=1.
- dut_halt asserted on the cycle the counter expires -> DUMP entered, timeout=0.
- DUMP_WORDS=4, RD_LAT=2, dmem preloaded 0xA0..0xA3 at 0x10010000.. -> 4 contiguous dump_valid pulses starting 2 cycles after the first read, dump_addr 0x10010000..0x1001000C, then the CLEAR pass leaves all 4 words 0 and end_sim=1.
- RST_n pulsed low mid-DUMP -> all outputs at reset values immediately; a new start reruns the full sequence correctly.
